// File: rtl/image_capture.sv
// Thresholds an 8-bit raster pixel stream and packs complete 28x28 frames into
// pixel_data (bit i = pixel i). Define IMAGE_CAPTURE_DBUF_EN for double buffering.
module image_capture #(
  parameter int THRESHOLD = 128,
  parameter int NPIX      = 784
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pix_valid,
  output logic            pix_ready,
  input  logic [7:0]      pix_data,
  input  logic            pix_sof,
  output logic [NPIX-1:0] pixel_data,
  output logic            frame_valid,
  input  logic            frame_ack,
  output logic            sof_err,
  output logic [7:0]      frame_count
);

  // Pixel handshake: a beat transfers on a rising edge where pix_valid && pix_ready;
  // frame handshake: the consumer takes the frame on an edge where frame_valid && frame_ack.
  localparam logic [7:0] THR  = 8'(THRESHOLD);
  localparam logic [9:0] LAST = 10'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  logic [NPIX-1:0] frame_buf;
  logic [9:0]      cnt;
  logic            pix_bit;
  logic            beat;
  logic [NPIX-1:0] done_frame;

  assign pix_bit = (pix_data >= THR);
  assign beat    = pix_valid && pix_ready;

  // The final bit is merged combinationally so pixel_data loads on the same edge.
  always_comb begin
    done_frame           = frame_buf;
    done_frame[NPIX-1]   = pix_bit;
  end

`ifdef IMAGE_CAPTURE_DBUF_EN
  assign pix_ready = !((state == FILL) && (cnt == LAST) && frame_valid && !frame_ack);
`else
  assign pix_ready = (state != HOLD);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      frame_buf   <= '0;
      pixel_data  <= '0;
      frame_valid <= 1'b0;
      sof_err     <= 1'b0;
      frame_count <= '0;
    end else begin
      sof_err <= 1'b0;
`ifdef IMAGE_CAPTURE_DBUF_EN
      // A completion on the same edge overrides this clear below.
      if (frame_valid && frame_ack) frame_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (beat && pix_sof) begin
            frame_buf[0] <= pix_bit;
            cnt          <= 10'd1;
            state        <= FILL;
          end
        end
        FILL: begin
          if (beat) begin
            if (pix_sof) begin
              frame_buf[0] <= pix_bit;
              cnt          <= 10'd1;
              sof_err      <= 1'b1;
            end else begin
              frame_buf[cnt] <= pix_bit;
              if (cnt == LAST) begin
                pixel_data  <= done_frame;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 8'd1;
                cnt         <= '0;
`ifdef IMAGE_CAPTURE_DBUF_EN
                state       <= IDLE;
`else
                state       <= HOLD;
`endif
              end else begin
                cnt <= cnt + 10'd1;
              end
            end
          end
        end
        HOLD: begin
          if (frame_ack) begin
            frame_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_capture.sv
// Directed bench for image_capture: frame assembly, threshold, restart, backpressure,
// reset discard and (with IMAGE_CAPTURE_DBUF_EN) the double-buffer stall.
module tb_image_capture;

  localparam int NPIX = 784;

  logic            clk;
  logic            resetn;
  logic            pix_valid;
  logic            pix_ready;
  logic [7:0]      pix_data;
  logic            pix_sof;
  logic [NPIX-1:0] pixel_data;
  logic            frame_valid;
  logic            frame_ack;
  logic            sof_err;
  logic [7:0]      frame_count;

  logic [NPIX-1:0] exp_q[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  int              sof_pulses = 0;

  image_capture #(.THRESHOLD(128), .NPIX(NPIX)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pixel_data (pixel_data),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .sof_err    (sof_err),
    .frame_count(frame_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (resetn && sof_err) sof_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // pixel pattern generators, indexed by frame position
  function automatic logic [7:0] pix_val(input int kind, input int i);
    case (kind)
      0: pix_val = (i % 2 == 0) ? 8'd200 : 8'd50;
      1: pix_val = (i == 0) ? 8'd127 : (i == 1) ? 8'd128 : (i == 2) ? 8'd255 : 8'((i * 37) % 256);
      2: pix_val = 8'((i * 13 + 5) % 256);
      3: pix_val = 8'((i * 7) % 256);
      default: pix_val = 8'd255;
    endcase
  endfunction

  function automatic logic [NPIX-1:0] model_frame(input int kind);
    logic [NPIX-1:0] f;
    for (int i = 0; i < NPIX; i++) f[i] = (pix_val(kind, i) >= 8'd128);
    return f;
  endfunction

  // driver
  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic sof);
    int n;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    n = 0;
    while (!pix_ready && n < 1000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 1000) check("beat_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_range(input int kind, input int first, input int last, input logic sof_first);
    for (int i = first; i <= last; i++) send_beat(pix_val(kind, i), sof_first && (i == first));
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    @(posedge clk);
    #1 frame_ack = 1'b0;
  endtask

  // scoreboard: compare the published frame against the oldest expected one
  task automatic expect_frame(input string tag);
    logic [NPIX-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_frame_valid"}, 64'(frame_valid), 64'd1);
      check({tag, "_pixel_eq"}, 64'(pixel_data == e), 64'd1);
    end
  endtask

  logic [NPIX-1:0] held;
  int              bad;

  initial begin
    resetn = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; frame_ack = 1'b0;
    do_reset(3);

    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_sof_err",     64'(sof_err),     64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_pixel_zero",  64'(pixel_data == '0), 64'd1);
    check("rst_pix_ready",   64'(pix_ready),   64'd1);

    // checkerboard
    exp_q.push_back(model_frame(0));
    send_range(0, 0, NPIX - 1, 1'b1);
    expect_frame("checker");
    check("checker_low32", 64'(pixel_data[31:0]), 64'h5555_5555);
    check("checker_count", 64'(frame_count), 64'd1);

`ifndef IMAGE_CAPTURE_DBUF_EN
    held = pixel_data;
    bad  = 0;
    pix_valid = 1'b1; pix_data = 8'd255; pix_sof = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pix_ready !== 1'b0 || pixel_data !== held || frame_valid !== 1'b1) bad++;
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    check("hold_stall_errors", 64'(bad), 64'd0);
    check("hold_count", 64'(frame_count), 64'd1);
`endif
    #1 ack_frame();
    check("ack_frame_valid", 64'(frame_valid), 64'd0);
    check("ack_pix_ready",   64'(pix_ready),   64'd1);

    // threshold edge
    exp_q.push_back(model_frame(1));
    send_range(1, 0, NPIX - 1, 1'b1);
    check("thresh_bits", 64'(pixel_data[2:0]), 64'b110);
    expect_frame("thresh");
    check("thresh_count", 64'(frame_count), 64'd2);
    ack_frame();

    // mid-frame SOF restart
    send_range(4, 0, 299, 1'b1);
    check("midsof_no_err_yet", 64'(sof_pulses), 64'd0);
    exp_q.push_back(model_frame(2));
    send_beat(pix_val(2, 0), 1'b1);
    check("midsof_err_pulse", 64'(sof_err), 64'd1);
    send_range(2, 1, NPIX - 1, 1'b0);
    expect_frame("midsof");
    check("midsof_pulses", 64'(sof_pulses), 64'd1);
    check("midsof_count", 64'(frame_count), 64'd3);
    ack_frame();

    // reset mid-frame
    send_range(4, 0, 399, 1'b1);
    do_reset(2);
    check("midrst_frame_valid", 64'(frame_valid), 64'd0);
    check("midrst_count",       64'(frame_count), 64'd0);
    check("midrst_pixel_zero",  64'(pixel_data == '0), 64'd1);
    check("midrst_sof_err",     64'(sof_err), 64'd0);
    check("midrst_pix_ready",   64'(pix_ready), 64'd1);
    send_range(3, 0, 99, 1'b0);
    check("idle_discard_valid", 64'(frame_valid), 64'd0);
    exp_q.push_back(model_frame(3));
    send_range(3, 0, NPIX - 1, 1'b1);
    expect_frame("fresh");
    check("fresh_count", 64'(frame_count), 64'd1);

`ifdef IMAGE_CAPTURE_DBUF_EN
    // back-to-back frames without ack: the second frame's final beat stalls
    exp_q.push_back(model_frame(2));
    send_range(2, 0, NPIX - 2, 1'b1);
    check("dbuf_held_valid", 64'(frame_valid), 64'd1);
    check("dbuf_held_frame", 64'(pixel_data == model_frame(3)), 64'd1);
    pix_valid = 1'b1; pix_data = pix_val(2, NPIX - 1); pix_sof = 1'b0;
    #1 check("dbuf_stall", 64'(pix_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1 check("dbuf_stall_hold", 64'(pix_ready), 64'd0);
    check("dbuf_stall_frame", 64'(pixel_data == model_frame(3)), 64'd1);
    check("dbuf_stall_count", 64'(frame_count), 64'd1);
    frame_ack = 1'b1;
    #1 check("dbuf_release", 64'(pix_ready), 64'd1);
    @(posedge clk);
    #1 pix_valid = 1'b0; frame_ack = 1'b0;
    expect_frame("dbuf_second");
    check("dbuf_count", 64'(frame_count), 64'd2);
    ack_frame();
    check("dbuf_ack_valid", 64'(frame_valid), 64'd0);
`else
    ack_frame();
    check("final_ack_valid", 64'(frame_valid), 64'd0);
`endif

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/image_capture.md
# image_capture

Assembles one 28x28 binarized image from an 8-bit grayscale raster pixel stream into the 784-bit `pixel_data` vector consumed by the network's image memory. It is the writer side of that interface: it thresholds each incoming pixel, packs it into frame position `row*28+col`, and publishes only complete frames with a valid/ack handshake. It sits between the pixel source (camera/drawing front end or host loader) and the inference pipeline.

## Interface
- `THRESHOLD`, 128: a pixel becomes 1 when `pix_data >= THRESHOLD` (unsigned 8-bit compare); otherwise 0.
- `NPIX`, 784: pixels per frame; must be ≤ 1024.

Ports:
- `clk` input 1: the single clock; all state changes on the rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `pix_valid` input 1: a pixel beat is present.
- `pix_ready` output 1: block accepts a beat this cycle; a beat transfers when `pix_valid && pix_ready`.
- `pix_data` input 8: grayscale pixel value.
- `pix_sof` input 1: marks the beat as pixel 0 (start of frame).
- `pixel_data` output NPIX: last completed frame; bit i = pixel i.
- `frame_valid` output 1: `pixel_data` holds an unconsumed frame.
- `frame_ack` input 1: consumer takes the frame; only meaningful while `frame_valid` is high.
- `sof_err` output 1: one-cycle pulse when SOF arrives mid-frame.
- `frame_count` output 8: count of completed frames; wraps from 255 to 0.

## Operation
- Internal build register `buf[NPIX-1:0]` and 10-bit `cnt`; `pixel_data` is a separate output register that changes only on frame completion.
- States:
  - IDLE: `pix_ready=1`.
    - Beat with `pix_sof=0`: accepted and discarded.
    - Beat with `pix_sof=1`: writes `buf[0]`, sets `cnt=1`, and moves to FILL.
  - FILL: `pix_ready=1`.
    - Beat with `pix_sof=0`: writes `buf[cnt]` and increments `cnt`.
    - Beat with `pix_sof=1`: restarts the frame (writes `buf[0]`, `cnt=1`) and pulses `sof_err`; bits not yet rewritten are don't-care and are overwritten before completion.
    - Completion: the beat accepted at `cnt==NPIX-1` completes the frame. `pixel_data` is loaded with `buf` (including that final bit), `frame_valid` is set, `frame_count` increments, and the state moves to HOLD.
  - HOLD: `pix_ready=0`. When `frame_ack` is sampled high, `frame_valid` clears and the state moves to IDLE.
- `frame_ack` while `frame_valid=0` is ignored.
- Reset values: IDLE, `cnt=0`, `buf=0`, `pixel_data=0`, `frame_valid=0`, `sof_err=0`, `frame_count=0`. `pix_ready=1` from the first cycle after reset.
- Reset asserted mid-frame or in HOLD discards the partial or pending frame. No `frame_valid` is produced for that frame.

## Timing
- `pix_ready` is a combinational function of state, plus `frame_valid`/`frame_ack`/`cnt` in the configured variant.
- `pixel_data`, `frame_valid` and `frame_count` update on the edge that accepts the final beat; they are visible the next cycle (latency 1).
- `frame_ack` high at edge N: `frame_valid=0` after edge N. The next frame's SOF can be accepted on edge N+1.
- Minimum frame time is NPIX cycles at full throughput. Gaps (`pix_valid=0`) are allowed anywhere and do not change state.
- `sof_err` is high for exactly the cycle after the offending beat.

## Configuration
- `IMAGE_CAPTURE_DBUF_EN` defined (double buffering):
  - HOLD state is removed. After completion the block returns to IDLE and `pix_ready` stays 1, so the next frame fills `buf` while `pixel_data` is held.
  - The final beat of a frame is stalled (`pix_ready=0` when `cnt==NPIX-1`) only while `frame_valid=1 && frame_ack=0`.
  - If completion and `frame_ack` occur on the same edge, the new frame loads and `frame_valid` stays 1.
  - `pixel_data` never changes while `frame_valid=1` unless `frame_ack` is high that cycle.
- Not defined: single buffer, behaviour as described in Operation, with `pix_ready=0` for the whole HOLD period.

## Test plan
- **Checkerboard frame:** reset, then stream 784 beats with SOF on the first, `pix_data` alternating 200/50 -> `frame_valid` 1 cycle after the last beat, `pixel_data` = 784'h…5555 (bit 0 = 1, bit 1 = 0), `frame_count=1`.
- **Threshold edge:** pixels 127, 128 and 255 at indices 0, 1 and 2 -> bits 0/1/1.
- **Mid-frame SOF:** 300 beats, then a new SOF plus 783 more beats -> one `sof_err` pulse. The completed frame reflects only the restarted frame, and `frame_count` increments once.
- **Backpressure (single buffer):** complete a frame and withhold `frame_ack` for 50 cycles -> `pix_ready=0` throughout and `pixel_data` stable. Ack -> `frame_valid` falls next cycle, `pix_ready=1`.
- **Reset mid-frame:** `resetn=0` after 400 beats -> all outputs return to reset values; a fresh 784-beat frame then completes normally with `frame_count=1`.
- **DBUF_EN:** two back-to-back frames with no ack until the second's final beat -> that final beat stalls. Ack -> `pixel_data` switches to frame 2 on the same edge and `frame_valid` stays 1.
